object_plotter: RTL

Rectangle renderer at the far end of the game-logic plot interface. It accepts one plot request: object type, new and old top-left corners, and rectangle size, qualified by `startPlot`. It then erases the old rectangle and draws the new one, one pixel per cycle, onto the VGA adapter pixel-write port. It sits between the game-logic block and the DE2 VGA adapter, and reports `busy` and `done` back to the requester.

---
 rtl/object_plotter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/object_plotter.sv
// Rectangle plotter: erases the old rectangle then draws the new one, one pixel per clock.
// Build option PLOTTER_ERASE_EN enables the erase pass; without it only the draw pass runs.
module object_plotter #(
   parameter logic [7:0] MAX_X         = 8'd159,
   parameter logic [6:0] MAX_Y         = 7'd119,
   parameter logic [2:0] BG_COLOUR     = 3'b000,
   parameter logic [2:0] BALL_COLOUR   = 3'b111,
   parameter logic [2:0] PADDLE_COLOUR = 3'b010,
   parameter logic [2:0] BLOCK_COLOUR  = 3'b100
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       startPlot,
   input  logic [1:0] object,
   input  logic [7:0] newX,
   input  logic [6:0] newY,
   input  logic [7:0] oldX,
   input  logic [6:0] oldY,
   input  logic [7:0] sizeX,
   input  logic [6:0] sizeY,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

   state_t     state, state_nxt;
   logic [1:0] obj_q;
   logic [7:0] new_x_q, size_x_q;
   logic [6:0] new_y_q, size_y_q;
   logic [7:0] ox;
   logic [6:0] oy;
   logic       last_col, last_row, accept, null_req;
   logic [7:0] base_x_p0;
   logic [6:0] base_y_p0;
   logic [8:0] sum_x_p0;
   logic [7:0] sum_y_p0;
   logic [2:0] colour_p0;
   logic       vld_p0;

`ifdef PLOTTER_ERASE_EN
   logic [7:0] old_x_q;
   logic [6:0] old_y_q;
`else
   logic       unused_old;
   assign unused_old = ^{oldX, oldY};
`endif

   function automatic logic [2:0] obj_colour(input logic [1:0] obj);
      case (obj)
         2'b00:   obj_colour = BALL_COLOUR;
         2'b01:   obj_colour = PADDLE_COLOUR;
         2'b10:   obj_colour = BLOCK_COLOUR;
         default: obj_colour = BG_COLOUR;
      endcase
   endfunction

   // Clipping: a pixel is written only when both unwrapped sums land on screen.
   function automatic logic on_screen(input logic [8:0] sx, input logic [7:0] sy);
      on_screen = (sx <= {1'b0, MAX_X}) && (sy <= {1'b0, MAX_Y});
   endfunction

   assign last_col = (ox == size_x_q - 8'd1);
   assign last_row = (oy == size_y_q - 7'd1);
   assign accept   = (state == IDLE) && startPlot;
   assign null_req = (object == 2'b11) || (sizeX == 8'd0) || (sizeY == 7'd0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (startPlot) begin
               if (null_req) state_nxt = DONE;
`ifdef PLOTTER_ERASE_EN
               else          state_nxt = ERASE;
`else
               else          state_nxt = DRAW;
`endif
            end
         end
         ERASE:   if (last_col && last_row) state_nxt = DRAW;
         DRAW:    if (last_col && last_row) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch: only these copies are used once a request is accepted.
   always_ff @(posedge clk) begin
      if (accept) begin
         obj_q    <= object;
         new_x_q  <= newX;
         new_y_q  <= newY;
         size_x_q <= sizeX;
         size_y_q <= sizeY;
`ifdef PLOTTER_ERASE_EN
         old_x_q  <= oldX;
         old_y_q  <= oldY;
`endif
      end
   end

   // Scan offsets: ox inner, oy outer; both wrap to 0 at the end of each pass.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ox <= 8'd0;
         oy <= 7'd0;
      end else if (state == ERASE || state == DRAW) begin
         if (last_col) begin
            ox <= 8'd0;
            oy <= last_row ? 7'd0 : oy + 7'd1;
         end else begin
            ox <= ox + 8'd1;
         end
      end else begin
         ox <= 8'd0;
         oy <= 7'd0;
      end
   end

   // Stage p0: pixel address and colour for the current offset.
   always_comb begin
      base_x_p0 = new_x_q;
      base_y_p0 = new_y_q;
      colour_p0 = obj_colour(obj_q);
`ifdef PLOTTER_ERASE_EN
      if (state == ERASE) begin
         base_x_p0 = old_x_q;
         base_y_p0 = old_y_q;
         colour_p0 = BG_COLOUR;
      end
`endif
      sum_x_p0 = {1'b0, base_x_p0} + {1'b0, ox};
      sum_y_p0 = {1'b0, base_y_p0} + {1'b0, oy};
      vld_p0   = (state == ERASE) || (state == DRAW);
   end

   // Stage p1: registered pixel-write port and handshake.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vga_x      <= 8'd0;
         vga_y      <= 7'd0;
         vga_colour <= 3'd0;
         vga_plot   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         vga_plot <= vld_p0 && on_screen(sum_x_p0, sum_y_p0);
         busy     <= (state != IDLE);
         done     <= (state == DONE);
         if (vld_p0) begin
            vga_x      <= sum_x_p0[7:0];
            vga_y      <= sum_y_p0[6:0];
            vga_colour <= colour_p0;
         end
      end
   end

endmodule
